pool_window_buffer: RTL

POOL_WINDOW_BUFFER -- requirements
Module: pool_window_buffer

---
 rtl/pool_pkg.sv | 15 +
 rtl/pool_line_buf.sv | 29 ++
 rtl/pool_window_buffer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 pooling window buffer.
package pool_pkg;

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_state_e;

    // Lane positions inside a packed window; TL occupies the MSBs.
    localparam int TL = 3;
    localparam int TR = 2;
    localparam int BL = 1;
    localparam int BR = 0;

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer: single write port, two combinational read ports.
// Contents are never cleared; each even row overwrites before the odd row reads.
module pool_line_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 28,
    localparam int AW        = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr0_i,
    output logic [DATA_WIDTH-1:0] rdata0_o,
    input  logic [AW-1:0]         raddr1_i,
    output logic [DATA_WIDTH-1:0] rdata1_o
);

    logic [DATA_WIDTH-1:0] mem_q [IMG_WIDTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/pool_window_buffer.sv
// Builds 2x2 pooling windows from a raster pixel stream with a registered output.
// Optional frame_done pulse is enabled by defining POOL_WINDOW_FRAME_DONE_EN.
module pool_window_buffer
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [4*DATA_WIDTH-1:0] win_data,
`ifdef POOL_WINDOW_FRAME_DONE_EN
    output logic                    frame_done,
`endif
    output row_state_e              dbg_state
);

    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    row_state_e                    state_q;
    logic [CW-1:0]                 col_q, col_d;
    logic [RW-1:0]                 row_q, row_d;
    logic [DATA_WIDTH-1:0]         hold_q;
    logic                          win_valid_q;
    logic [4*DATA_WIDTH-1:0]       win_data_q;
    logic [3:0][DATA_WIDTH-1:0]    win_n;
    logic [DATA_WIDTH-1:0]         lb_prev, lb_cur;
    logic                          accept, handoff, complete, col_last, row_last;

    assign accept   = in_valid && in_ready;
    assign handoff  = win_valid_q && win_ready;
    assign col_last = (col_q == CW'(IMG_WIDTH - 1));
    assign row_last = (row_q == RW'(IMG_HEIGHT - 1));
    assign complete = accept && (state_q == ROW_ODD) && col_q[0];

    pool_line_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .IMG_WIDTH (IMG_WIDTH)
    ) u_line_buf (
        .clk     (clk),
        .we_i    (accept && (state_q == ROW_EVEN)),
        .waddr_i (col_q),
        .wdata_i (in_data),
        .raddr0_i(col_q - CW'(1)),
        .rdata0_o(lb_prev),
        .raddr1_i(col_q),
        .rdata1_o(lb_cur)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        win_n     = '0;
        win_n[TL] = lb_prev;
        win_n[TR] = lb_cur;
        win_n[BL] = hold_q;
        win_n[BR] = in_data;
    end

`ifdef POOL_WINDOW_FRAME_DONE_EN
    // Tags the window in the output register as the last one of its frame.
    logic last_q;
    logic frame_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (complete) begin
                last_q <= row_last && col_last;
            end
            frame_done_q <= handoff && last_q;
        end
    end

    assign frame_done = frame_done_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ROW_EVEN;
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (accept && col_last) begin
                state_q <= (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
            end
            if (accept && (state_q == ROW_ODD) && !col_q[0]) begin
                hold_q <= in_data;
            end
            // A completing pixel can only arrive when the output slot is free or being handed off.
            if (complete) begin
                win_valid_q <= 1'b1;
                win_data_q  <= win_n;
            end else if (handoff) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready  = !(win_valid_q && !win_ready);
    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;
    assign dbg_state = state_q;

endmodule
